// File: rtl/analyzer_pkg.sv
// Shared types and default sizes for the analyzer capture path.
package analyzer_pkg;

    localparam int unsigned DefAddrW = 25;
    localparam int unsigned DefDataW = 32;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StPost,
        StDone
    } cap_state_e;

endpackage

// File: rtl/capture_wr_buffer.sv
// One-entry holding register between the capture FSM and the trace RAM write port.
// A new sample may load in the same cycle the pending one is written out.
module capture_wr_buffer
    import analyzer_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_write_allowed,
    output logic              o_load_ok,
    output logic              o_write_req,
    output logic [ADDR_W-1:0] o_write_addr,
    output logic [DATA_W-1:0] o_write_data
);

    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_addr <= i_load_addr;
            r_data <= i_load_data;
        end else if (i_write_allowed) begin
            r_full <= 1'b0;
        end
    end

    assign o_load_ok    = !r_full || i_write_allowed;
    assign o_write_req  = r_full;
    assign o_write_addr = r_addr;
    assign o_write_data = r_data;

endmodule

// File: rtl/analyzer_capture_fsm.sv
// Capture controller: stores qualified samples in a circular trace RAM until trigger + post count.
// Optional CAPTURE_DECIMATE_EN adds a decim port keeping only every (decim+1)th valid sample.
module analyzer_capture_fsm
    import analyzer_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              trigger,
`ifdef CAPTURE_DECIMATE_EN
    input  logic [7:0]        decim,
`endif
    input  logic [ADDR_W-1:0] post_trig_count,
    output logic              write_req,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic              write_allowed,
    output logic              idle,
    output logic              done,
    output logic              triggered,
    output logic              overflow,
    output logic [31:0]       sampleNumber_Begin,
    output logic [31:0]       sampleNumber_End
);

    localparam logic [ADDR_W:0]   Depth   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FillOne = (ADDR_W + 1)'(1);

    cap_state_e        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_post_left;
    logic [ADDR_W-1:0] r_begin;
    logic [ADDR_W-1:0] r_end;
    logic [ADDR_W:0]   r_fill;
    logic              r_idle;
    logic              r_done;
    logic              r_triggered;
    logic              r_overflow;

    logic w_capturing;
    logic w_open;
    logic w_eligible;
    logic w_load_ok;
    logic w_accept;
    logic w_drop;
    logic w_start_ok;

    assign w_capturing = (r_state == StPre) || (r_state == StPost);
    // Once the post count is used up, further samples are simply not wanted (not dropped).
    assign w_open      = (r_state == StPre) || (r_post_left != '0);
    assign w_start_ok  = start && !abort && ((r_state == StIdle) || (r_state == StDone));
    assign w_accept    = w_capturing && w_open && sample_valid && w_eligible && w_load_ok && !abort;
    assign w_drop      = w_capturing && w_open && sample_valid && w_eligible && !w_load_ok && !abort;

`ifdef CAPTURE_DECIMATE_EN
    logic [7:0] r_decim_cnt;

    assign w_eligible = (r_decim_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_decim_cnt <= 8'd0;
        end else if (w_capturing && sample_valid) begin
            r_decim_cnt <= (r_decim_cnt >= decim) ? 8'd0 : r_decim_cnt + 8'd1;
        end
    end
`else
    assign w_eligible = 1'b1;
`endif

    capture_wr_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_buffer (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_flush         (abort),
        .i_load          (w_accept),
        .i_load_addr     (r_wr_ptr),
        .i_load_data     (sample_data),
        .i_write_allowed (write_allowed),
        .o_load_ok       (w_load_ok),
        .o_write_req     (write_req),
        .o_write_addr    (write_addr),
        .o_write_data    (write_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_idle      <= 1'b1;
            r_done      <= 1'b0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_post_left <= '0;
            r_begin     <= '0;
            r_end       <= '0;
        end else if (abort) begin
            r_state     <= StIdle;
            r_idle      <= 1'b1;
            r_done      <= 1'b0;
            r_triggered <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
                if (r_fill != Depth) r_fill <= r_fill + FillOne;
            end
            if (w_drop) r_overflow <= 1'b1;
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state     <= StPre;
                        r_idle      <= 1'b0;
                        r_done      <= 1'b0;
                        r_triggered <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_wr_ptr    <= '0;
                        r_fill      <= '0;
                    end
                end
                StPre: begin
                    if (w_accept && trigger) begin
                        r_state     <= StPost;
                        r_triggered <= 1'b1;
                        r_post_left <= post_trig_count;
                    end
                end
                StPost: begin
                    if (w_accept) r_post_left <= r_post_left - PtrOne;
                    // Wait for the holding register to drain so done implies RAM coherent.
                    if ((r_post_left == '0) && !write_req) begin
                        r_state <= StDone;
                        r_idle  <= 1'b1;
                        r_done  <= 1'b1;
                        r_end   <= r_wr_ptr - PtrOne;
                        r_begin <= r_wr_ptr - r_fill[ADDR_W-1:0];
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign idle               = r_idle;
    assign done               = r_done;
    assign triggered          = r_triggered;
    assign overflow           = r_overflow;
    assign sampleNumber_Begin = 32'(r_begin);
    assign sampleNumber_End   = 32'(r_end);

endmodule

// File: tb/tb_analyzer_capture_fsm.sv
// Self-checking bench for analyzer_capture_fsm with a 16-entry trace RAM.
module tb_analyzer_capture_fsm;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset, start, abort, sample_valid, trigger, write_allowed;
    logic [DW-1:0] sample_data;
    logic [AW-1:0] post_trig_count;
    logic          write_req;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          idle, done, triggered, overflow;
    logic [31:0]   sn_begin, sn_end;
`ifdef CAPTURE_DECIMATE_EN
    logic [7:0]    decim;
`endif

    int            vectors     = 0;
    int            miscompares = 0;
    int            wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic [DW-1:0] drv_data[$];
    bit            drv_trig[$];

    analyzer_capture_fsm #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .abort              (abort),
        .sample_valid       (sample_valid),
        .sample_data        (sample_data),
        .trigger            (trigger),
`ifdef CAPTURE_DECIMATE_EN
        .decim              (decim),
`endif
        .post_trig_count    (post_trig_count),
        .write_req          (write_req),
        .write_addr         (write_addr),
        .write_data         (write_data),
        .write_allowed      (write_allowed),
        .idle               (idle),
        .done               (done),
        .triggered          (triggered),
        .overflow           (overflow),
        .sampleNumber_Begin (sn_begin),
        .sampleNumber_End   (sn_end)
    );

    always #5 clk = ~clk;

    // Inputs change just after posedge, so the negedge view is what the next posedge sees.
    always @(negedge clk) begin
        if (write_req && write_allowed) begin
            wq_addr.push_back(int'(write_addr));
            wq_data.push_back(write_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        sample_valid = 1'b0;
        trigger      = 1'b0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        drv_data.delete();
        drv_trig.delete();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic feed(input logic [DW-1:0] d, input bit trig);
        sample_valid = 1'b1;
        sample_data  = d;
        trigger      = trig;
        tick();
        drv_data.push_back(d);
        drv_trig.push_back(trig);
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        vectors++;
        if ({idle, done, triggered, overflow, write_req} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags: got idle/done/trig/ovf/req=%b want 10000",
                     {idle, done, triggered, overflow, write_req});
        end
        vectors++;
        if (sn_begin !== 32'd0 || sn_end !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_begin_end: got %0d/%0d want 0/0", sn_begin, sn_end);
        end
    endtask

    task automatic test_basic();
        post_trig_count = AW'(3);
        write_allowed   = 1'b1;
        do_start();
        feed($urandom, 1'b0);
        vectors++;
        if (write_req !== 1'b1 || write_addr !== 4'd0 || write_data !== drv_data[0]) begin
            miscompares++;
            $display("FAIL basic_latency: got req=%b addr=%0d want req=1 addr=0", write_req, write_addr);
        end
        for (int i = 1; i < 8; i++) feed($urandom, 1'b0);
        feed($urandom, 1'b1);
        for (int i = 0; i < 3; i++) feed($urandom, 1'b0);
        for (int i = 0; i < 2; i++) feed($urandom, 1'($urandom_range(0, 1)));
        wait_done(40);
        vectors++;
        if ({idle, done, triggered, overflow} !== 4'b1110) begin
            miscompares++;
            $display("FAIL basic_flags: got idle/done/trig/ovf=%b want 1110",
                     {idle, done, triggered, overflow});
        end
        vectors++;
        if (wq_addr.size() != 12) begin
            miscompares++;
            $display("FAIL basic_count: got %0d writes want 12", wq_addr.size());
        end
        for (int i = 0; i < 12 && i < wq_addr.size(); i++) begin
            vectors++;
            if (wq_addr[i] != i || wq_data[i] !== drv_data[i]) begin
                miscompares++;
                $display("FAIL basic_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h",
                         i, wq_addr[i], wq_data[i], i, drv_data[i]);
            end
        end
        vectors++;
        if (sn_begin !== 32'd0 || sn_end !== 32'd11) begin
            miscompares++;
            $display("FAIL basic_begin_end: got %0d/%0d want 0/11", sn_begin, sn_end);
        end
    endtask

    task automatic test_wrap();
        post_trig_count = AW'(2);
        write_allowed   = 1'b1;
        do_start();
        for (int i = 0; i < 19; i++) feed($urandom, 1'b0);
        feed($urandom, 1'b1);
        for (int i = 0; i < 2; i++) feed($urandom, 1'b0);
        wait_done(40);
        vectors++;
        if (done !== 1'b1 || wq_addr.size() != 22) begin
            miscompares++;
            $display("FAIL wrap_count: got done=%b writes=%0d want done=1 writes=22",
                     done, wq_addr.size());
        end
        for (int i = 0; i < 22 && i < wq_addr.size(); i++) begin
            vectors++;
            if (wq_addr[i] != i % DEPTH || wq_data[i] !== drv_data[i]) begin
                miscompares++;
                $display("FAIL wrap_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h",
                         i, wq_addr[i], wq_data[i], i % DEPTH, drv_data[i]);
            end
        end
        vectors++;
        if (sn_begin !== 32'd6 || sn_end !== 32'd5) begin
            miscompares++;
            $display("FAIL wrap_begin_end: got %0d/%0d want 6/5", sn_begin, sn_end);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d0, d3;
        d0 = $urandom;
        d3 = $urandom;
        post_trig_count = AW'(0);
        write_allowed   = 1'b0;
        do_start();
        feed(d0, 1'b0);
        vectors++;
        if ({write_req, overflow} !== 2'b10 || write_addr !== 4'd0 || write_data !== d0) begin
            miscompares++;
            $display("FAIL bp_first: got req/ovf=%b addr=%0d want 10 addr=0",
                     {write_req, overflow}, write_addr);
        end
        for (int i = 0; i < 2; i++) begin
            feed($urandom, 1'b0);
            vectors++;
            if ({write_req, overflow} !== 2'b11 || write_addr !== 4'd0 || write_data !== d0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got req/ovf=%b addr=%0d data=%h want 11 addr=0 data=%h",
                         i, {write_req, overflow}, write_addr, write_data, d0);
            end
        end
        write_allowed = 1'b1;
        feed(d3, 1'b1);
        vectors++;
        if (write_addr !== 4'd1 || write_data !== d3 || triggered !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_resume: got addr=%0d trig=%b want addr=1 trig=1", write_addr, triggered);
        end
        wait_done(20);
        vectors++;
        if (wq_addr.size() != 2 || done !== 1'b1 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_done: got writes=%0d done=%b ovf=%b want 2/1/1",
                     wq_addr.size(), done, overflow);
        end else begin
            vectors++;
            if (wq_addr[0] != 0 || wq_data[0] !== d0 || wq_addr[1] != 1 || wq_data[1] !== d3) begin
                miscompares++;
                $display("FAIL bp_writes: got %0d:%h %0d:%h want 0:%h 1:%h",
                         wq_addr[0], wq_data[0], wq_addr[1], wq_data[1], d0, d3);
            end
        end
        vectors++;
        if (sn_begin !== 32'd0 || sn_end !== 32'd1) begin
            miscompares++;
            $display("FAIL bp_begin_end: got %0d/%0d want 0/1", sn_begin, sn_end);
        end
    endtask

    task automatic test_abort();
        post_trig_count = AW'(5);
        write_allowed   = 1'b1;
        do_start();
        feed($urandom, 1'b0);
        feed($urandom, 1'b0);
        feed($urandom, 1'b1);
        write_allowed = 1'b0;
        feed($urandom, 1'b0);
        vectors++;
        if (write_req !== 1'b1 || triggered !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: got req=%b trig=%b want 1/1", write_req, triggered);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({idle, done, triggered, write_req} !== 4'b1000) begin
            miscompares++;
            $display("FAIL abort_state: got idle/done/trig/req=%b want 1000",
                     {idle, done, triggered, write_req});
        end
        write_allowed   = 1'b1;
        post_trig_count = AW'(0);
        do_start();
        vectors++;
        if (overflow !== 1'b0 || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_restart: got ovf=%b idle=%b want 0/0", overflow, idle);
        end
        feed($urandom, 1'b1);
        vectors++;
        if (write_req !== 1'b1 || write_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_addr0: got req=%b addr=%0d want 1/0", write_req, write_addr);
        end
        wait_done(20);
        vectors++;
        if (done !== 1'b1 || wq_addr.size() != 1 || sn_begin !== 32'd0 || sn_end !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_done: got done=%b writes=%0d begin=%0d end=%0d want 1/1/0/0",
                     done, wq_addr.size(), sn_begin, sn_end);
        end
    endtask

    task automatic test_idle_trigger();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sample_valid = 1'b1;
        trigger      = 1'b1;
        sample_data  = $urandom;
        tick();
        sample_valid = 1'b0;
        trigger      = 1'b0;
        vectors++;
        if ({idle, triggered, write_req} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_trig: got idle/trig/req=%b want 100", {idle, triggered, write_req});
        end
        post_trig_count = AW'(1);
        write_allowed   = 1'b1;
        do_start();
        vectors++;
        if ({idle, triggered} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_start: got idle/trig=%b want 00", {idle, triggered});
        end
        start = 1'b1;
        feed($urandom, 1'b1);
        start = 1'b0;
        vectors++;
        if ({idle, done, triggered, write_req} !== 4'b0011 || write_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_pre_trig: got idle/done/trig/req=%b addr=%0d want 0011 addr=0",
                     {idle, done, triggered, write_req}, write_addr);
        end
        feed($urandom, 1'b0);
        wait_done(20);
        vectors++;
        if (done !== 1'b1 || wq_addr.size() != 2 || sn_begin !== 32'd0 || sn_end !== 32'd1) begin
            miscompares++;
            $display("FAIL idle_done: got done=%b writes=%0d begin=%0d end=%0d want 1/2/0/1",
                     done, wq_addr.size(), sn_begin, sn_end);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int          npre, nval, cyc, post, t, n;
            bit          tg;
            logic [31:0] exp_begin, exp_end;
            npre = $urandom_range(0, 24);
            post = $urandom_range(0, 5);
            nval = 0;
            cyc  = 0;
            post_trig_count = AW'(post);
            write_allowed   = 1'b1;
            do_start();
            while (!done && cyc < 200) begin
                if ($urandom_range(0, 3) != 0) begin
                    tg = (nval == npre) || ($urandom_range(0, 9) == 0);
                    feed($urandom, tg);
                    nval++;
                end else begin
                    trigger = 1'($urandom_range(0, 1));
                    tick();
                    trigger = 1'b0;
                end
                cyc++;
            end
            t = -1;
            for (int i = 0; i < drv_trig.size(); i++) if (drv_trig[i] && t < 0) t = i;
            n = (t < 0) ? 0 : t + post + 1;
            if (n > drv_data.size()) n = drv_data.size();
            exp_end   = 32'((n - 1) % DEPTH);
            exp_begin = (n >= DEPTH) ? 32'(n % DEPTH) : 32'd0;
            vectors++;
            if (done !== 1'b1 || wq_addr.size() != n) begin
                miscompares++;
                $display("FAIL rand%0d_count: got done=%b writes=%0d want done=1 writes=%0d",
                         it, done, wq_addr.size(), n);
            end
            for (int i = 0; i < n && i < wq_addr.size(); i++) begin
                vectors++;
                if (wq_addr[i] != i % DEPTH || wq_data[i] !== drv_data[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h",
                             it, i, wq_addr[i], wq_data[i], i % DEPTH, drv_data[i]);
                end
            end
            vectors++;
            if (sn_begin !== exp_begin || sn_end !== exp_end || overflow !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_begin_end: got %0d/%0d ovf=%b want %0d/%0d ovf=0",
                         it, sn_begin, sn_end, overflow, exp_begin, exp_end);
            end
            feed($urandom, 1'b1);
            vectors++;
            if ({done, write_req} !== 2'b10) begin
                miscompares++;
                $display("FAIL rand%0d_done_hold: got done/req=%b want 10", it, {done, write_req});
            end
        end
    endtask

`ifdef CAPTURE_DECIMATE_EN
    task automatic test_decimate();
        int elig[$];
        int k, n;
        decim           = 8'd2;
        post_trig_count = AW'(1);
        write_allowed   = 1'b1;
        do_start();
        for (int i = 0; i < 9; i++) feed($urandom, (i == 1) || (i == 3));
        wait_done(20);
        for (int i = 0; i < 9; i++) if (i % 3 == 0) elig.push_back(i);
        k = -1;
        for (int i = 0; i < elig.size(); i++) if (drv_trig[elig[i]] && k < 0) k = i;
        n = k + 1 + 1;
        vectors++;
        if (done !== 1'b1 || wq_addr.size() != n) begin
            miscompares++;
            $display("FAIL decim_count: got done=%b writes=%0d want 1/%0d", done, wq_addr.size(), n);
        end
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            vectors++;
            if (wq_addr[i] != i || wq_data[i] !== drv_data[elig[i]]) begin
                miscompares++;
                $display("FAIL decim_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h",
                         i, wq_addr[i], wq_data[i], i, drv_data[elig[i]]);
            end
        end
        vectors++;
        if (sn_begin !== 32'd0 || sn_end !== 32'(n - 1)) begin
            miscompares++;
            $display("FAIL decim_begin_end: got %0d/%0d want 0/%0d", sn_begin, sn_end, n - 1);
        end
        decim = 8'd0;
    endtask
`endif

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        sample_valid    = 1'b0;
        sample_data     = '0;
        trigger         = 1'b0;
        write_allowed   = 1'b0;
        post_trig_count = '0;
`ifdef CAPTURE_DECIMATE_EN
        decim           = 8'd0;
`endif
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_abort();
        test_idle_trigger();
        test_random();
`ifdef CAPTURE_DECIMATE_EN
        test_decimate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
